// File: rtl/twos_complement_serial.sv
// twos_complement_serial: bit-serial two's complement engine (negate / absolute value).
// A WIDTH-bit operand is accepted on a valid/ready handshake, then processed LSB-first,
// one bit per clock, with the copy-through-first-one-then-invert rule. The result is held
// behind a second valid/ready handshake.
// Optional build macro: TWOS_SAT_EN -- when defined, the most-negative operand saturates to
// the largest positive value instead of wrapping back to itself. out_ovf flags it either way.
module twos_complement_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH - 1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             mode_q, mode_d;
  logic             msb_q, msb_d;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;

  // Serial datapath: current bit, its transformed value, and the word it completes.
  logic             in_bit;
  logic             copy_through;
  logic             out_bit;
  logic [WIDTH-1:0] shifted;
  logic             ovf_det;
  logic [WIDTH-1:0] final_data;

  // Per-bit transform: copy until the first one is passed (or always, for abs of a non-negative).
  always_comb begin
    in_bit       = shift_q[0];
    copy_through = ~seen_q | (mode_q & ~msb_q);
    out_bit      = copy_through ? in_bit : ~in_bit;
    shifted      = {out_bit, shift_q[WIDTH-1:1]};
    // Only the operand 100..0 with a negative MSB can produce 100..0 as its result.
    ovf_det      = msb_q & (shifted == MIN_NEG);
`ifdef TWOS_SAT_EN
    final_data   = ovf_det ? MAX_POS : shifted;
`else
    final_data   = shifted;
`endif
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      mode_q     <= 1'b0;
      msb_q      <= 1'b0;
      seen_q     <= 1'b0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      mode_q     <= mode_d;
      msb_q      <= msb_d;
      seen_q     <= seen_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  // Next-state and datapath update; everything holds unless a state says otherwise.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    mode_d     = mode_q;
    msb_d      = msb_q;
    seen_d     = seen_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          shift_d = in_data;
          mode_d  = mode;
          msb_d   = in_data[WIDTH-1];
          seen_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_d = shifted;
        seen_d  = seen_q | in_bit;
        if (cnt_q == LAST_BIT) begin
          out_data_d = final_data;
          out_ovf_d  = ovf_det;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake flags decode straight from the state register.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_twos_complement_serial.sv
// Directed bench for twos_complement_serial at WIDTH=8 and WIDTH=16 with a result scoreboard.
module tb_twos_complement_serial;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid8, in_ready8, mode8, out_valid8, out_ready8, out_ovf8, busy8;
  logic [7:0]  in_data8, out_data8;
  logic        in_valid16, in_ready16, mode16, out_valid16, out_ready16, out_ovf16, busy16;
  logic [15:0] in_data16, out_data16;

  typedef struct {
    logic [63:0] data;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  twos_complement_serial #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .mode(mode8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_ovf(out_ovf8), .busy(busy8)
  );

  twos_complement_serial #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16), .mode(mode16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16),
    .out_ovf(out_ovf16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: result of negate/abs plus the overflow flag.
  function automatic exp_t model(input int w, input logic [63:0] x, input logic m);
    exp_t        e;
    logic [63:0] mask, xm, neg;
    mask = (64'd1 << w) - 64'd1;
    xm   = x & mask;
    neg  = (~xm + 64'd1) & mask;
    e.data = (m && !xm[w-1]) ? xm : neg;
    e.ovf  = (xm == (64'd1 << (w - 1)));
`ifdef TWOS_SAT_EN
    if (e.ovf) e.data = mask >> 1;
`endif
    return e;
  endfunction

  function automatic logic rdy(input int w);
    return (w == 8) ? in_ready8 : in_ready16;
  endfunction
  function automatic logic ovld(input int w);
    return (w == 8) ? out_valid8 : out_valid16;
  endfunction
  function automatic logic bsy(input int w);
    return (w == 8) ? busy8 : busy16;
  endfunction
  function automatic logic oovf(input int w);
    return (w == 8) ? out_ovf8 : out_ovf16;
  endfunction
  function automatic logic [63:0] odata(input int w);
    return (w == 8) ? 64'(out_data8) : 64'(out_data16);
  endfunction

  task automatic drive(input int w, input logic v, input logic [63:0] d, input logic m);
    if (w == 8) begin
      in_valid8 = v; in_data8 = d[7:0]; mode8 = m;
    end else begin
      in_valid16 = v; in_data16 = d[15:0]; mode16 = m;
    end
  endtask

  task automatic set_oready(input int w, input logic r);
    if (w == 8) out_ready8 = r;
    else        out_ready16 = r;
  endtask

  // One operation: accept, measure latency, optional backpressure and busy-time poke, handoff.
  task automatic run_op(input string tag, input int w, input logic [63:0] x, input logic m,
                        input int hold, input bit inject);
    int   n;
    int   lat;
    exp_t e;
    n = 0;
    while (!rdy(w) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_ready"}, 64'(rdy(w)), 64'd1);
    drive(w, 1'b1, x, m);
    @(posedge clk); #1;
    drive(w, 1'b0, {$urandom, $urandom}, ~m);
    sb.push_back(model(w, x, m));
    check({tag, "_busy"}, 64'(bsy(w)), 64'd1);
    lat = 0;
    while (!ovld(w) && lat < 200) begin
      if (inject) drive(w, (lat == 3), 64'h33, 1'b0);
      @(posedge clk); #1;
      lat++;
    end
    drive(w, 1'b0, 64'h0, 1'b0);
    check({tag, "_latency"}, 64'(lat), 64'(w));
    if (sb.size() == 0) begin
      check({tag, "_scoreboard"}, 64'd0, 64'd1);
      e.data = '0; e.ovf = 1'b0;
    end else begin
      e = sb.pop_front();
    end
    check({tag, "_data"}, odata(w), e.data);
    check({tag, "_ovf"}, 64'(oovf(w)), 64'(e.ovf));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 64'(ovld(w)), 64'd1);
      check({tag, "_hold_data"}, odata(w), e.data);
      check({tag, "_hold_inready"}, 64'(rdy(w)), 64'd0);
    end
    set_oready(w, 1'b1);
    @(posedge clk); #1;
    set_oready(w, 1'b0);
    check({tag, "_post_ready"}, 64'(rdy(w)), 64'd1);
    check({tag, "_post_valid"}, 64'(ovld(w)), 64'd0);
    check({tag, "_post_busy"}, 64'(bsy(w)), 64'd0);
  endtask

  initial begin
    int seen_valid;
    rst = 1'b1;
    drive(8, 1'b0, 64'h0, 1'b0);
    drive(16, 1'b0, 64'h0, 1'b0);
    out_ready8 = 1'b0; out_ready16 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_inready8", 64'(in_ready8), 64'd1);
    check("rst_outvalid8", 64'(out_valid8), 64'd0);
    check("rst_outdata8", 64'(out_data8), 64'd0);
    check("rst_ovf8", 64'(out_ovf8), 64'd0);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_inready16", 64'(in_ready16), 64'd1);
    check("rst_outdata16", 64'(out_data16), 64'd0);

    run_op("neg05",   8, 64'h05, 1'b0, 0, 1'b0);
    run_op("neg00",   8, 64'h00, 1'b0, 0, 1'b0);
    run_op("absFB",   8, 64'hFB, 1'b1, 0, 1'b0);
    run_op("abs7F",   8, 64'h7F, 1'b1, 0, 1'b0);
    run_op("absFF",   8, 64'hFF, 1'b1, 0, 1'b0);
    run_op("neg80",   8, 64'h80, 1'b0, 0, 1'b0);
    run_op("abs80",   8, 64'h80, 1'b1, 0, 1'b0);
    run_op("bp_negA5", 8, 64'hA5, 1'b0, 5, 1'b0);
    run_op("inj_neg3C", 8, 64'h3C, 1'b0, 0, 1'b1);

    // Abort mid-SHIFT: accept, let bits 0..2 go, reset while bit 3 is in flight.
    drive(8, 1'b1, 64'h5A, 1'b0);
    @(posedge clk); #1;
    drive(8, 1'b0, 64'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_inready", 64'(in_ready8), 64'd1);
    check("abort_outvalid", 64'(out_valid8), 64'd0);
    check("abort_outdata", 64'(out_data8), 64'd0);
    check("abort_busy", 64'(busy8), 64'd0);
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid8) seen_valid++;
    end
    check("abort_no_valid", 64'(seen_valid), 64'd0);
    run_op("after_abort_neg01", 8, 64'h01, 1'b0, 0, 1'b0);

    run_op("w16_neg8000", 16, 64'h8000, 1'b0, 0, 1'b0);
    run_op("w16_abs8000", 16, 64'h8000, 1'b1, 0, 1'b0);
    run_op("w16_neg1234", 16, 64'h1234, 1'b0, 2, 1'b0);
    run_op("w16_absFFFE", 16, 64'hFFFE, 1'b1, 0, 1'b1);
    run_op("w16_abs0001", 16, 64'h0001, 1'b1, 0, 1'b0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
